// File: rtl/key_debounce.sv
// Per-key synchronizer and stability-counter debouncer for the key PIO.
// Emits clean levels plus one-cycle press/release pulses.
module key_debounce #(
   parameter int NKEYS           = 8,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   input  logic [NKEYS-1:0] key_raw,
   output logic [NKEYS-1:0] key_level,
   output logic [NKEYS-1:0] key_press,
   output logic [NKEYS-1:0] key_release
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   typedef enum logic {
      STABLE   = 1'b0,
      COUNTING = 1'b1
   } state_t;

   logic [NKEYS-1:0] sync1;
   logic [NKEYS-1:0] sync2;

   state_t [NKEYS-1:0]        state;
   state_t [NKEYS-1:0]        state_nxt;
   logic   [NKEYS-1:0][CW-1:0] cnt;
   logic   [NKEYS-1:0][CW-1:0] cnt_nxt;
   logic   [NKEYS-1:0]        level_nxt;
   logic   [NKEYS-1:0]        press_nxt;
   logic   [NKEYS-1:0]        release_nxt;

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         sync1       <= '0;
         sync2       <= '0;
         state       <= {NKEYS{STABLE}};
         cnt         <= '0;
         key_level   <= '0;
         key_press   <= '0;
         key_release <= '0;
      end else begin
         sync1       <= key_raw ^ {NKEYS{ACTIVE_LOW}};
         sync2       <= sync1;
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         key_level   <= level_nxt;
         key_press   <= press_nxt;
         key_release <= release_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      level_nxt   = key_level;
      press_nxt   = '0;
      release_nxt = '0;
      for (int i = 0; i < NKEYS; i++) begin
         unique case (state[i])
            STABLE: begin
               if (sync2[i] != key_level[i]) begin
                  state_nxt[i] = COUNTING;
                  cnt_nxt[i]   = ONE;
               end
            end
            COUNTING: begin
               if (sync2[i] == key_level[i]) begin
                  // bounce: drop the pending change silently
                  state_nxt[i] = STABLE;
                  cnt_nxt[i]   = '0;
               end else if (cnt[i] == LAST) begin
                  state_nxt[i]   = STABLE;
                  cnt_nxt[i]     = '0;
                  level_nxt[i]   = sync2[i];
                  press_nxt[i]   = sync2[i];
                  release_nxt[i] = ~sync2[i];
               end else begin
                  cnt_nxt[i] = cnt[i] + ONE;
               end
            end
            default: begin
               state_nxt[i] = STABLE;
               cnt_nxt[i]   = '0;
            end
         endcase
      end
   end

endmodule

// File: doc/key_debounce.md
# key_debounce

Input conditioner placed directly upstream of the platform's 8-bit key PIO input (`key_wire_export`). It synchronizes raw push-button/switch inputs into the `clk_clk` domain, normalizes their polarity, and debounces each key independently with a per-key stability counter. It drives clean level outputs for the PIO plus single-cycle press/release pulses for local logic.

## Interface
- `NKEYS`, 8: number of independent key inputs.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a change (10 ms at 50 MHz); legal range ≥ 2.
- `ACTIVE_LOW`, 1: 1 = raw pin low means pressed; 0 = raw pin high means pressed.

- `clk_clk`  in  1  system clock; the only clock.
- `reset_reset`  in  1  synchronous, active-high reset.
- `key_raw`  in  NKEYS  asynchronous raw pin levels.
- `key_level`  out  NKEYS  debounced state, 1 = pressed; wired to `key_wire_export`.
- `key_press`  out  NKEYS  one-cycle pulse when a key's `key_level` goes 0→1.
- `key_release`  out  NKEYS  one-cycle pulse when a key's `key_level` goes 1→0.

## Operation
- Synchronizer: two flops per key. `sync1 <= key_raw ^ {NKEYS{ACTIVE_LOW}}`, then `sync2 <= sync1`. After this, 1 = pressed.
- Per key, there is one stable register (`key_level[i]`) and one counter `cnt[i]`. The counter is `$clog2(DEBOUNCE_CYCLES)` bits wide and is unsigned.
- Each key has a two-state FSM:
  - STABLE (`cnt==0`, `sync2==key_level`): hold.
  - If `sync2 != key_level`, go to COUNTING with `cnt <= 1`.
  - COUNTING, case `sync2 == key_level` (a bounce): `cnt <= 0`, return to STABLE. Output is unchanged and no pulse is generated.
  - COUNTING, case `sync2 != key_level` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - COUNTING, case `sync2 != key_level` and `cnt == DEBOUNCE_CYCLES-1`: `key_level <= sync2`, `cnt <= 0`, return to STABLE. `key_press` or `key_release` is registered high for exactly that one cycle.
- The counter never exceeds `DEBOUNCE_CYCLES-1`, so no wrap-around is possible.
- Keys are fully independent. Any number of keys may change, bounce, or pulse in the same cycle.
- `key_press` and `key_release` for the same key are never high together.
- Reset (synchronous, takes priority over all updates):
  - `sync1`, `sync2`, `key_level`, `key_press`, `key_release` all reset to 0 (released).
  - All counters reset to 0.
- Reset asserted mid-count discards the pending change with no pulse.
- A key held pressed through reset release is treated as a new change: `key_level` rises after the full latency, with a `key_press` pulse.

## Timing
- Call edge E the rising edge at which `sync1` first captures a new raw value.
- `sync2` changes at E+1.
- The counter increments on edges E+2 … E+D, where D = `DEBOUNCE_CYCLES`.
- `key_level` and the pulse update at edge E+D+1, so total latency is D+1 edges after capture.
- The pulse output is high for the single cycle following edge E+D+1 and clears at E+D+2.
- A raw glitch seen by `sync2` for fewer than D consecutive edges produces no output change.
- All outputs are registered; there are no combinational paths from `key_raw` to any output.
- There is no handshake. Consumers sample `key_level` at any time; pulses are not held.

## Test plan
Bench runs with `DEBOUNCE_CYCLES=4`, `NKEYS=8`, `ACTIVE_LOW=1`.
- Reset: hold `reset_reset=1` for 3 cycles with `key_raw=8'hFF` → `key_level=0`, `key_press=0`, `key_release=0` during reset and for 6 cycles after.
- Clean press: drive `key_raw[0]` 1→0 captured at edge E → `key_level[0]=1` and `key_press[0]=1` after edge E+5. `key_press[0]` returns to 0 after E+6. Other bits stay 0.
- Bounce rejection: drive `key_raw[2]` low for 3 cycles, high for 1, then low steady → no change until 4 consecutive stable edges are seen at `sync2`. Exactly one `key_press[2]` pulse.
- Release plus simultaneity: keys 1 and 5 pressed and stable; release key 1 while pressing key 6 in the same cycle → `key_release[1]` and `key_press[6]` pulse in the same cycle, and `key_level` goes from 8'h22 to 8'h60.
- Reset mid-count: start pressing key 3, assert reset 2 edges into counting, release reset with the key still low → no pulse during reset. `key_level[3]` rises with a `key_press[3]` pulse D+1 edges after `sync1` recaptures the pressed value post-reset.
- Polarity: with `ACTIVE_LOW=0`, `key_raw=8'h01` steady → `key_level=8'h01` after latency, `key_press[0]` pulse once.
